rhd_packetizer: RTL
===================

Name: rhd_packetizer

Overview:
- Sits between the RHD acquisition engine's sample FIFO (already in the DMA clock domain) and the AXI DMA S2MM stream input.
- Collects per-sample-period channel frames, groups cfg_batch frames per packet, prepends a 64-bit magic number and a frame timestamp, and emits one AXI-Stream packet with tlast for each DMA transfer.

Parameters:
- FRAME_WORDS, 16, 32-bit words per input frame (32 channels x 16 bit, packed two per word)
- MAGIC, 64'hC691_1999_2702_1942, packet header magic number
- BATCH_W, 8, width of cfg_batch

Ports:
- clk_dma  in  1  stream clock (250 MHz)
- rst_dma  in  1  synchronous reset, active-high
- cfg_enable  in  1  packetizing enable (AXI-lite control bit, already synchronised)
- cfg_batch  in  BATCH_W  frames per packet; 0 treated as 1
- s_axis_tdata  in  32  input sample word
- s_axis_tvalid  in  1  input valid
- s_axis_tready  out  1  input ready
- s_axis_tlast  in  1  last word of an input frame
- m_axis_tdata  out  32  packet word to DMA
- m_axis_tvalid  out  1  output valid
- m_axis_tready  in  1  DMA ready
- m_axis_tlast  out  1  last word of packet
- stat_pkt_count  out  32  packets completed (wraps)
- stat_frame_err  out  1  one-cycle pulse on frame misalignment

Behaviour:
- Reset: all outputs 0; FSM to IDLE; timestamp, word and frame counters 0.
- Single output register stage. Load condition: !m_axis_tvalid || m_axis_tready. m_axis_tvalid/tdata/tlast stay stable until accepted (AXIS rules).
- s_axis_tready = (state==DATA) && load condition && !padding. A data word reaches the output one cycle after its handshake.
- Timestamp: 32-bit count of input frames completed (a tlast is accepted, or a padding/discard recovery completes). Wraps 0xFFFFFFFF->0. Counted in every state, including frames discarded in IDLE.
- FSM:
  - IDLE -> MAGIC_LO when cfg_enable=1 and s_axis_tvalid=1. On this transition latch batch = max(cfg_batch,1). In IDLE, s_axis_tready=0.
  - MAGIC_LO: emit MAGIC[31:0] -> MAGIC_HI.
  - MAGIC_HI: emit MAGIC[63:32] -> TSTAMP.
  - TSTAMP: emit the timestamp value at entry to the state -> DATA.
  - DATA: forward words. Word counter runs 0..FRAME_WORDS-1 and frame counter runs 0..batch-1. m_axis_tlast=1 on word FRAME_WORDS-1 of frame batch-1. When that word is accepted into the output register -> IDLE (CHECKSUM if the option is enabled), and stat_pkt_count increments when the tlast beat handshakes on the output.
  - A header state advances only when its word loads into the output register.
- Early s_axis_tlast (word index < FRAME_WORDS-1):
  - word is forwarded; stat_frame_err pulses;
  - s_axis_tready drops while the frame is padded with 0x00000000 up to FRAME_WORDS words;
  - packet length is preserved.
- Missing tlast at word FRAME_WORDS-1:
  - word is forwarded; stat_frame_err pulses;
  - subsequent input words are accepted and dropped up to and including the next tlast; then the next frame starts.
- cfg_enable low mid-packet: the current packet completes, then the FSM stays in IDLE. cfg_batch changes take effect only at the next packet start.
- rst_dma mid-packet: output dropped immediately (tvalid=0), no tlast generated, all counters cleared.
- Packet length in words: 3 + batch*FRAME_WORDS (+1 with the option).

Optional Feature:
- RHD_PKT_CHECKSUM_EN defined:
  - adds a CHECKSUM state after DATA;
  - emits the 32-bit modulo-2^32 sum of all data words in the packet (padding included, header excluded);
  - m_axis_tlast moves to the checksum word; sum clears at packet start.
- Undefined: no CHECKSUM state; tlast on the last data word.

Test Plan:
- cfg_batch=2, enable, 32 contiguous words 0x1..0x20 with tlast on words 16 and 32 -> output C691_1999... as 0x27021942, 0xC6911999, 0x00000000, then 0x1..0x20. tlast only on 0x20. stat_pkt_count=1.
- Random m_axis_tready (50%) over 3 packets with cfg_batch=1 -> no data loss or reordering, tdata stable while stalled; timestamps in headers 0, 1, 2.
- tlast on word 10 of a frame -> stat_frame_err pulse; words 11-15 output as 0x00000000; next frame aligned.
- No tlast for 20 words -> error pulse at word 15; 4 words dropped; the following frame is forwarded intact.
- cfg_batch=0 -> treated as 1 (19-word packet). cfg_enable dropped mid-packet -> packet completes, no new header afterwards.
- RHD_PKT_CHECKSUM_EN, data 0xFFFFFFFF x16 -> final word 0xFFFFFFF0 with tlast. Also, rst_dma pulsed mid-DATA -> tvalid=0 next cycle and all stats 0.

Source files
------------

// File: rtl/rhd_packetizer.sv
// RHD sample-frame packetizer: wraps cfg_batch input frames with a magic/timestamp header into one AXIS packet.
// Define RHD_PKT_CHECKSUM_EN to append a modulo-2^32 data checksum word carrying tlast.
//
// state    | meaning
// IDLE     | waiting for enable and input data; latches batch on exit
// MAGIC_LO | emitting MAGIC[31:0]
// MAGIC_HI | emitting MAGIC[63:32]
// TSTAMP   | emitting frame timestamp
// DATA     | forwarding / padding frame words
// CHECKSUM | emitting data checksum (RHD_PKT_CHECKSUM_EN only)
module rhd_packetizer #(
  parameter int          FRAME_WORDS = 16,
  parameter logic [63:0] MAGIC       = 64'hC691_1999_2702_1942,
  parameter int          BATCH_W     = 8
) (
  input  logic               clk_dma,
  input  logic               rst_dma,
  input  logic               cfg_enable,
  input  logic [BATCH_W-1:0] cfg_batch,
  input  logic [31:0]        s_axis_tdata,
  input  logic               s_axis_tvalid,
  output logic               s_axis_tready,
  input  logic               s_axis_tlast,
  output logic [31:0]        m_axis_tdata,
  output logic               m_axis_tvalid,
  input  logic               m_axis_tready,
  output logic               m_axis_tlast,
  output logic [31:0]        stat_pkt_count,
  output logic               stat_frame_err
);

  localparam int                WORD_W    = (FRAME_WORDS > 1) ? $clog2(FRAME_WORDS) : 1;
  localparam logic [WORD_W-1:0] LAST_WORD = WORD_W'(FRAME_WORDS - 1);

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] MAGIC_LO = 3'd1;
  localparam logic [2:0] MAGIC_HI = 3'd2;
  localparam logic [2:0] TSTAMP   = 3'd3;
  localparam logic [2:0] DATA     = 3'd4;
  localparam logic [2:0] CHECKSUM = 3'd5;

  logic [2:0]         state;
  logic [BATCH_W-1:0] batch;
  logic [BATCH_W-1:0] batch_next;
  logic [WORD_W-1:0]  word_cnt;
  logic [BATCH_W-1:0] frame_cnt;
  logic               padding;
  logic               discard;
  logic [31:0]        tstamp;

  logic               load;
  logic               in_hs;
  logic               fwd;
  logic               emit_data;
  logic               last_word;
  logic               last_frame;
  logic               early_last;
  logic               missing_last;
  logic               ts_inc;
  logic               pkt_done;
  logic [31:0]        data_word;

`ifdef RHD_PKT_CHECKSUM_EN
  logic [31:0]        sum;
`endif

  assign load = !m_axis_tvalid || m_axis_tready;

  // Words after a missing tlast are swallowed even while the output stalls or the FSM sits in IDLE,
  // so resynchronisation never waits on the DMA.
  assign s_axis_tready = discard || ((state == DATA) && load && !padding);

  assign in_hs        = s_axis_tvalid && s_axis_tready;
  assign fwd          = in_hs && !discard;
  assign emit_data    = (state == DATA) && load && (padding || fwd);
  assign last_word    = (word_cnt == LAST_WORD);
  assign last_frame   = (frame_cnt == (batch - BATCH_W'(1)));
  assign early_last   = fwd && s_axis_tlast && !last_word;
  assign missing_last = fwd && !s_axis_tlast && last_word;
  assign data_word    = padding ? 32'h0 : s_axis_tdata;
  assign batch_next   = (cfg_batch == '0) ? BATCH_W'(1) : cfg_batch;
  assign pkt_done     = m_axis_tvalid && m_axis_tready && m_axis_tlast;

  // One increment per input frame: at its aligned tlast, at the end of padding, or at the tlast ending a discard.
  assign ts_inc = (fwd && s_axis_tlast && last_word)
               || (emit_data && padding && last_word)
               || (in_hs && discard && s_axis_tlast);

  always_ff @(posedge clk_dma) begin
    if (rst_dma) begin
      state          <= IDLE;
      batch          <= '0;
      word_cnt       <= '0;
      frame_cnt      <= '0;
      padding        <= 1'b0;
      discard        <= 1'b0;
      tstamp         <= '0;
      m_axis_tdata   <= '0;
      m_axis_tvalid  <= 1'b0;
      m_axis_tlast   <= 1'b0;
      stat_pkt_count <= '0;
      stat_frame_err <= 1'b0;
`ifdef RHD_PKT_CHECKSUM_EN
      sum            <= '0;
`endif
    end else begin
      stat_frame_err <= early_last || missing_last;

      if (pkt_done)
        stat_pkt_count <= stat_pkt_count + 32'd1;

      if (ts_inc)
        tstamp <= tstamp + 32'd1;

      if (early_last)
        padding <= 1'b1;
      else if (emit_data && padding && last_word)
        padding <= 1'b0;

      if (missing_last)
        discard <= 1'b1;
      else if (in_hs && discard && s_axis_tlast)
        discard <= 1'b0;

      if (load) begin
        m_axis_tvalid <= 1'b0;
        m_axis_tlast  <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (cfg_enable && s_axis_tvalid && !discard) begin
            state     <= MAGIC_LO;
            batch     <= batch_next;
            word_cnt  <= '0;
            frame_cnt <= '0;
`ifdef RHD_PKT_CHECKSUM_EN
            sum       <= '0;
`endif
          end
        end

        MAGIC_LO: begin
          if (load) begin
            m_axis_tdata  <= MAGIC[31:0];
            m_axis_tvalid <= 1'b1;
            state         <= MAGIC_HI;
          end
        end

        MAGIC_HI: begin
          if (load) begin
            m_axis_tdata  <= MAGIC[63:32];
            m_axis_tvalid <= 1'b1;
            state         <= TSTAMP;
          end
        end

        TSTAMP: begin
          if (load) begin
            m_axis_tdata  <= tstamp;
            m_axis_tvalid <= 1'b1;
            state         <= DATA;
          end
        end

        DATA: begin
          if (emit_data) begin
            m_axis_tdata  <= data_word;
            m_axis_tvalid <= 1'b1;
`ifdef RHD_PKT_CHECKSUM_EN
            sum           <= sum + data_word;
`endif
            if (last_word) begin
              word_cnt <= '0;
              if (last_frame) begin
                frame_cnt <= '0;
`ifdef RHD_PKT_CHECKSUM_EN
                state     <= CHECKSUM;
`else
                state        <= IDLE;
                m_axis_tlast <= 1'b1;
`endif
              end else begin
                frame_cnt <= frame_cnt + BATCH_W'(1);
              end
            end else begin
              word_cnt <= word_cnt + WORD_W'(1);
            end
          end
        end

`ifdef RHD_PKT_CHECKSUM_EN
        CHECKSUM: begin
          if (load) begin
            m_axis_tdata  <= sum;
            m_axis_tvalid <= 1'b1;
            m_axis_tlast  <= 1'b1;
            state         <= IDLE;
          end
        end
`endif

        default: state <= IDLE;
      endcase
    end
  end

endmodule
